lcd_ctrl: RTL and testbench

HD44780-compatible character-LCD controller that consumes the core's 32-bit LCD output register and turns each software request into a correctly timed bus write on the LCD pins. It sits outside the pipelined core, between the LSU's LCD register and the board pins. It runs an optional power-on initialisation sequence. A busy flag is returned for the LSU to map as a readable status, so firmware polls instead of bit-banging delays.

---
 rtl/lcd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD controller: turns start-bit edges of the core's LCD
// register into timed EN strobes, with optional power-on init and a 1-entry pending buffer.
module lcd_ctrl #(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_PULSE_CYC = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000,
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter bit          INIT_EN     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_busy,
  output logic        o_lcd_drop,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int unsigned CNT_MAX = (T_PWRUP_CYC > T_LONG_CYC) ? T_PWRUP_CYC : T_LONG_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [2:0]       INIT_LAST = 3'd5;

  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  // Power-on command table: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             init_run, init_run_n;
  logic [2:0]       init_idx, init_idx_n;
  logic             pend_v, pend_v_n;
  logic             pend_rs, pend_rs_n;
  logic [7:0]       pend_data, pend_data_n;
  logic             rs_n;
  logic [7:0]       data_n;
  logic             drop_n;
  logic             launch, take_pend, req_used;
  logic             l_rs;
  logic [7:0]       l_data;
  logic             is_long;

  logic             prev_start;
  logic             req_q;
  logic             req_rs;
  logic [7:0]       req_data;

  logic             unused_bits;
  assign unused_bits = ^{i_io_lcd[30:11], i_io_lcd[8]};

  assign o_lcd_rw = 1'b0;
  assign is_long  = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0);

  // Start-bit edge detect and request capture; prev resets high so a held bit never fires.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      prev_start <= 1'b1;
      req_q      <= 1'b0;
      req_rs     <= 1'b0;
      req_data   <= 8'h00;
      o_lcd_on   <= 1'b0;
    end else begin
      prev_start <= i_io_lcd[10];
      req_q      <= i_io_lcd[10] & ~prev_start;
      req_rs     <= i_io_lcd[9];
      req_data   <= i_io_lcd[7:0];
      o_lcd_on   <= i_io_lcd[31];
    end
  end

  // State, counter, pending buffer and registered pin outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= INIT_EN ? PWRUP : IDLE;
      cnt        <= INIT_EN ? LD_PWRUP : '0;
      init_run   <= INIT_EN;
      init_idx   <= 3'd0;
      pend_v     <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= 8'h00;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
      o_lcd_busy <= INIT_EN;
      o_lcd_drop <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      init_run   <= init_run_n;
      init_idx   <= init_idx_n;
      pend_v     <= pend_v_n;
      pend_rs    <= pend_rs_n;
      pend_data  <= pend_data_n;
      o_lcd_en   <= (state_n == PULSE);
      o_lcd_rs   <= rs_n;
      o_lcd_data <= data_n;
      o_lcd_busy <= (state_n != IDLE) || pend_v_n;
      o_lcd_drop <= drop_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    init_run_n  = init_run;
    init_idx_n  = init_idx;
    pend_v_n    = pend_v;
    pend_rs_n   = pend_rs;
    pend_data_n = pend_data;
    rs_n        = o_lcd_rs;
    data_n      = o_lcd_data;
    drop_n      = 1'b0;
    launch      = 1'b0;
    take_pend   = 1'b0;
    req_used    = 1'b0;
    l_rs        = 1'b0;
    l_data      = 8'h00;

    case (state)
      PWRUP: begin
        if (cnt == '0) begin
          launch = 1'b1;
          l_data = init_cmd(3'd0);
        end
      end
      IDLE: begin
        if (pend_v) begin
          launch    = 1'b1;
          take_pend = 1'b1;
          l_rs      = pend_rs;
          l_data    = pend_data;
        end else if (req_q) begin
          launch   = 1'b1;
          req_used = 1'b1;
          l_rs     = req_rs;
          l_data   = req_data;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = LD_PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = LD_HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = EXEC;
          cnt_n   = is_long ? LD_LONG : LD_EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          if (init_run && (init_idx != INIT_LAST)) begin
            init_idx_n = init_idx + 3'd1;
            launch     = 1'b1;
            l_data     = init_cmd(init_idx + 3'd1);
          end else begin
            init_run_n = 1'b0;
            if (pend_v) begin
              launch    = 1'b1;
              take_pend = 1'b1;
              l_rs      = pend_rs;
              l_data    = pend_data;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (launch) begin
      state_n = SETUP;
      cnt_n   = LD_SETUP;
      rs_n    = l_rs;
      data_n  = l_data;
    end

    if (take_pend) pend_v_n = 1'b0;

    // A request not launched directly takes the (possibly just freed) buffer, else it is dropped.
    if (req_q && !req_used) begin
      if (!pend_v_n) begin
        pend_v_n    = 1'b1;
        pend_rs_n   = req_rs;
        pend_data_n = req_data;
      end else begin
        drop_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: one instance with power-on init, one without,
// both at shortened timing (setup 2, pulse 4, hold 2, exec 10, long 40, power-up 20).
module tb_lcd_ctrl;

  logic        clk;
  logic        rst_i, rst_d;
  logic [31:0] io_i, io_d;
  logic        busy_i, drop_i, on_i, en_i, rs_i, rw_i;
  logic [7:0]  data_i;
  logic        busy_d, drop_d, on_d, en_d, rs_d, rw_d;
  logic [7:0]  data_d;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] stim [$];
  int          busy_cnt, pulses, drop_cnt, first_busy, first_en, width_bad, gaps;
  logic        rs_or, busy_rs;
  logic [7:0]  busy_data;
  logic [7:0]  pdata [8];

  lcd_ctrl #(
    .T_SETUP_CYC(2), .T_PULSE_CYC(4), .T_HOLD_CYC(2), .T_EXEC_CYC(10),
    .T_LONG_CYC(40), .T_PWRUP_CYC(20), .INIT_EN(1'b1)
  ) dut_init (
    .i_clk(clk), .i_reset(rst_i), .i_io_lcd(io_i),
    .o_lcd_busy(busy_i), .o_lcd_drop(drop_i), .o_lcd_on(on_i), .o_lcd_en(en_i),
    .o_lcd_rs(rs_i), .o_lcd_rw(rw_i), .o_lcd_data(data_i)
  );

  lcd_ctrl #(
    .T_SETUP_CYC(2), .T_PULSE_CYC(4), .T_HOLD_CYC(2), .T_EXEC_CYC(10),
    .T_LONG_CYC(40), .T_PWRUP_CYC(20), .INIT_EN(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(rst_d), .i_io_lcd(io_d),
    .o_lcd_busy(busy_d), .o_lcd_drop(drop_d), .o_lcd_on(on_d), .o_lcd_en(en_d),
    .o_lcd_rs(rs_d), .o_lcd_rw(rw_d), .o_lcd_data(data_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply stim[k] before edge k, sample #1 after it, and summarise bus activity.
  task automatic observe(input int ncyc, input bit sel);
    logic b, e, r, d, pb, pe;
    logic [7:0] dat;
    int w;
    busy_cnt = 0; pulses = 0; drop_cnt = 0; first_busy = -1; first_en = -1;
    width_bad = 0; gaps = 0; rs_or = 1'b0; busy_rs = 1'b0; busy_data = 8'h00;
    w = 0; pe = 1'b0;
    pb = sel ? busy_i : busy_d;
    for (int k = 0; k < ncyc; k++) begin
      if (k < stim.size()) begin
        if (sel) io_i = stim[k]; else io_d = stim[k];
      end
      @(posedge clk); #1;
      b   = sel ? busy_i : busy_d;
      e   = sel ? en_i   : en_d;
      r   = sel ? rs_i   : rs_d;
      d   = sel ? drop_i : drop_d;
      dat = sel ? data_i : data_d;
      if (b) begin
        if (!pb && first_busy >= 0) gaps++;
        if (first_busy < 0) begin
          first_busy = k; busy_rs = r; busy_data = dat;
        end
        busy_cnt++;
      end
      if (e && !pe) begin
        if (pulses < 8) pdata[pulses] = dat;
        rs_or = rs_or | r;
        if (first_en < 0) first_en = k;
        pulses++;
        w = 0;
      end
      if (e) w++;
      if (!e && pe && w != 4) width_bad++;
      if (d) drop_cnt++;
      pb = b;
      pe = e;
    end
  endtask

  initial begin
    rst_i = 1'b0; rst_d = 1'b0; io_i = 32'h0; io_d = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_busy_init", 32'(busy_i), 32'h1);
    check("rst_busy",      32'(busy_d), 32'h0);
    check("rst_en",        32'(en_d),   32'h0);
    check("rst_en_init",   32'(en_i),   32'h0);
    check("rst_rs",        32'(rs_d),   32'h0);
    check("rst_data",      32'(data_d), 32'h0);
    check("rst_on",        32'(on_d),   32'h0);
    check("rst_drop",      32'(drop_d), 32'h0);
    check("rst_rw",        32'(rw_d),   32'h0);

    // 1: init sequence; the cycle before the first sampled edge is already busy
    rst_i = 1'b1;
    stim.delete();
    observe(200, 1'b1);
    check("init_busy_cycles", 32'(busy_cnt), 32'(158 - 1));
    check("init_pulses",      32'(pulses),   32'd6);
    check("init_first_en",    32'(first_en), 32'd21);
    check("init_width",       32'(width_bad), 32'd0);
    check("init_rs",          32'(rs_or),    32'h0);
    check("init_d0", 32'(pdata[0]), 32'h38);
    check("init_d1", 32'(pdata[1]), 32'h38);
    check("init_d2", 32'(pdata[2]), 32'h38);
    check("init_d3", 32'(pdata[3]), 32'h0C);
    check("init_d4", 32'(pdata[4]), 32'h01);
    check("init_d5", 32'(pdata[5]), 32'h06);
    check("init_idle", 32'(busy_i), 32'h0);

    // 2: single data write
    rst_d = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stim = '{32'h8000_0241, 32'h8000_0641};
    observe(30, 1'b0);
    check("wr_on",         32'(on_d),       32'h1);
    check("wr_first_busy", 32'(first_busy), 32'd2);
    check("wr_setup_rs",   32'(busy_rs),    32'h1);
    check("wr_setup_data", 32'(busy_data),  32'h41);
    check("wr_en_start",   32'(first_en),   32'd4);
    check("wr_width",      32'(width_bad),  32'd0);
    check("wr_pulses",     32'(pulses),     32'd1);
    check("wr_busy",       32'(busy_cnt),   32'd18);
    check("wr_rw",         32'(rw_d),       32'h0);

    // 3: clear display uses the long wait
    stim = '{32'h0000_0001, 32'h0000_0401};
    observe(60, 1'b0);
    check("clr_on",    32'(on_d),     32'h0);
    check("clr_rs",    32'(rs_or),    32'h0);
    check("clr_data",  32'(pdata[0]), 32'h01);
    check("clr_busy",  32'(busy_cnt), 32'd48);

    // 4: pending and drop
    stim = '{32'h041, 32'h441, 32'h042, 32'h442, 32'h043, 32'h443};
    observe(60, 1'b0);
    check("pend_pulses", 32'(pulses),   32'd2);
    check("pend_d0",     32'(pdata[0]), 32'h41);
    check("pend_d1",     32'(pdata[1]), 32'h42);
    check("pend_busy",   32'(busy_cnt), 32'd36);
    check("pend_gaps",   32'(gaps),     32'd0);
    check("pend_drop",   32'(drop_cnt), 32'd1);

    // 5: reset mid-pulse with a pending entry
    stim = '{32'h041, 32'h441, 32'h042, 32'h442};
    observe(6, 1'b0);
    check("mid_en_high", 32'(en_d),   32'h1);
    check("mid_busy",    32'(busy_d), 32'h1);
    #2 rst_d = 1'b0;
    #1;
    check("async_en",   32'(en_d),   32'h0);
    check("async_busy", 32'(busy_d), 32'h0);
    check("async_data", 32'(data_d), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_d = 1'b1;
    stim.delete();
    observe(40, 1'b0);
    check("post_rst_pulses", 32'(pulses),   32'd0);
    check("post_rst_busy",   32'(busy_cnt), 32'd0);

    // 6: start bit already high at reset release
    io_d = 32'h0000_0441;
    rst_d = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_d = 1'b1;
    observe(50, 1'b0);
    check("hi_rst_pulses", 32'(pulses),   32'd0);
    check("hi_rst_busy",   32'(busy_cnt), 32'd0);
    stim = '{32'h041, 32'h441};
    observe(30, 1'b0);
    check("hi_rst_one_pulse", 32'(pulses),     32'd1);
    check("hi_rst_data",      32'(pdata[0]),   32'h41);
    check("hi_rst_busy_len",  32'(busy_cnt),   32'd18);
    check("hi_rst_first",     32'(first_busy), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
